// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces presses and releases and
// strobes each accepted key code. Auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_TICKS   = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       key_flag,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      rs_meta;
  logic [3:0]      rs;
  logic [3:0]      cand;
  logic [DW-1:0]   div;
  logic [1:0]      col_idx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rel;
  logic            tick;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0]   rpt;
`endif

  if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  // Several closed rows resolve to the lowest row index.
  function automatic logic [1:0] lowest_zero(input logic [3:0] p);
    lowest_zero = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) lowest_zero = 2'(i);
    end
  endfunction

  assign tick = (div == DIV_LAST);
  assign col  = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SCAN;
      rs_meta  <= 4'hF;
      rs       <= 4'hF;
      cand     <= 4'hF;
      div      <= '0;
      col_idx  <= 2'd0;
      cnt      <= '0;
      rel      <= '0;
      value    <= 4'h0;
      key_flag <= 1'b0;
      key_down <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt      <= '0;
`endif
    end else begin
      // NOTE: all state here uses <= so every decision sees the pre-edge values.
      rs_meta  <= row;
      rs       <= rs_meta;
      div      <= tick ? '0 : div + 1'b1;
      key_flag <= 1'b0;

      if (tick) begin
        case (state)
          SCAN: begin
            if (rs == 4'hF) begin
              col_idx <= col_idx + 1'b1;
            end else begin
              cand  <= rs;
              cnt   <= CW'(1);
              state <= DEBOUNCE;
            end
          end

          DEBOUNCE: begin
            if (rs != cand) begin
              state   <= SCAN;
              col_idx <= col_idx + 1'b1;
              cnt     <= '0;
            end else if (cnt >= RUN_LAST) begin
              state    <= PRESSED;
              value    <= {lowest_zero(cand), col_idx};
              key_flag <= 1'b1;
              key_down <= 1'b1;
              cnt      <= '0;
              rel      <= '0;
`ifdef KEYPAD_REPEAT_EN
              rpt      <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          PRESSED: begin
            if (rs != 4'hF) begin
              // Any closed row restarts the release run; pattern changes never strobe.
              rel <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rpt >= RPT_LAST) begin
                rpt      <= '0;
                key_flag <= 1'b1;
              end else begin
                rpt <= rpt + 1'b1;
              end
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rpt <= '0;
`endif
              if (rel >= RUN_LAST) begin
                state    <= SCAN;
                key_down <= 1'b0;
                col_idx  <= col_idx + 1'b1;
                rel      <= '0;
              end else begin
                rel <= rel + 1'b1;
              end
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
